rotorb_state_ctrl: RTL

Owns the 64-entry x 6-bit rotor B permutation table for the Enigma datapath. It feeds the combinational rotor-B permute stage: the current table, the buffered encrypt/crypt-mode flags and the forward-lookup mode bits. It commits that stage's next-table result after each processed symbol. It also handles serial table load with a permutation-validity check, and returns the forward-substituted symbol through a valid/ready handshake.

---
 rtl/rotorb_state_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rotorb_state_ctrl.sv
// rotorb_state_ctrl
// Owns the 64 x 6-bit rotor B permutation table. Loads it serially with a
// duplicate-value check, looks up one symbol per transaction through a
// valid/ready handshake and commits the permute stage's next table once per
// processed symbol.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   load_start/valid/data       serial table load, entries in index order
//   load_done, perm_err         end-of-load pulse, sticky duplicate flag
//   in_valid/ready/symbol       input symbol handshake
//   encrypt, crypt_mode         per-symbol flags, buffered for the permute stage
//   encrypt_buf, crypt_mode_buf registered flags
//   rotorB_forward              low 2 bits of the looked-up entry
//   out_valid/ready/symbol      result handshake
//   rotorB_flat                 current table, entry i at [6i+5:6i]
//   rotorB_nxt_flat             next table from the permute stage
module rotorb_state_ctrl #(
  parameter int unsigned N_ENT = 64,
  parameter int unsigned SYM_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [SYM_W-1:0]         load_data,
  output logic                     load_done,
  output logic                     perm_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SYM_W-1:0]         in_symbol,
  input  logic                     encrypt,
  input  logic                     crypt_mode,
  output logic                     encrypt_buf,
  output logic                     crypt_mode_buf,
  output logic [1:0]               rotorB_forward,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SYM_W-1:0]         out_symbol,
  output logic [N_ENT*SYM_W-1:0]   rotorB_flat,
  input  logic [N_ENT*SYM_W-1:0]   rotorB_nxt_flat
);

  typedef enum logic [2:0] {StIdle, StLoad, StReady, StStep, StHold} state_e;

  state_e             r_state, w_state_nxt;
  logic [SYM_W-1:0]   r_table [N_ENT];
  logic [SYM_W-1:0]   r_idx;
  logic [N_ENT-1:0]   r_seen;
  logic               r_perm_err;
  logic               r_load_done;
  logic               r_enc_buf;
  logic               r_cm_buf;
  logic [SYM_W-1:0]   r_out_sym;
  logic [1:0]         r_fwd;

  logic w_start;
  logic w_load_wr;
  logic w_dup;
  logic w_last;
  logic w_accept;

  // load_start is honoured only outside the symbol pipeline (STEP/HOLD).
  assign w_start   = load_start &&
                     (r_state == StIdle || r_state == StLoad || r_state == StReady);
  // A restart cycle swallows any load_valid presented with it.
  assign w_load_wr = (r_state == StLoad) && load_valid && !load_start;
  assign w_dup     = r_seen[load_data];
  assign w_last    = w_load_wr && (r_idx == SYM_W'(N_ENT - 1));
  assign w_accept  = (r_state == StReady) && in_valid && !load_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_nxt = StLoad;
      end
      StLoad: begin
        if (load_start) begin
          w_state_nxt = StLoad;
        end else if (w_last) begin
          // Include the check on the final write itself.
          w_state_nxt = (r_perm_err || w_dup) ? StIdle : StReady;
        end
      end
      StReady: begin
        if (load_start)    w_state_nxt = StLoad;
        else if (in_valid) w_state_nxt = StStep;
      end
      StStep: w_state_nxt = StHold;
      StHold: begin
        if (out_ready) w_state_nxt = StReady;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) r_table[i] <= SYM_W'(i);
      r_idx       <= '0;
      r_seen      <= '0;
      r_perm_err  <= 1'b0;
      r_load_done <= 1'b0;
      r_enc_buf   <= 1'b0;
      r_cm_buf    <= 1'b0;
      r_out_sym   <= '0;
      r_fwd       <= '0;
    end else begin
      r_load_done <= w_last;

      if (w_start) begin
        r_idx      <= '0;
        r_seen     <= '0;
        r_perm_err <= 1'b0;
      end else if (w_load_wr) begin
        r_idx             <= r_idx + 1'b1;
        r_seen[load_data] <= 1'b1;
        if (w_dup) r_perm_err <= 1'b1;
      end

      if (w_load_wr) begin
        r_table[r_idx] <= load_data;
      end else if (r_state == StStep) begin
        // The permute stage returns the table unchanged when not stepping.
        for (int i = 0; i < N_ENT; i++) r_table[i] <= rotorB_nxt_flat[i*SYM_W +: SYM_W];
      end

      if (w_accept) begin
        r_enc_buf <= encrypt;
        r_cm_buf  <= crypt_mode;
        r_out_sym <= r_table[in_symbol];
        r_fwd     <= r_table[in_symbol][1:0];
      end
    end
  end

  always_comb begin
    rotorB_flat = '0;
    for (int i = 0; i < N_ENT; i++) rotorB_flat[i*SYM_W +: SYM_W] = r_table[i];
  end

  assign in_ready       = (r_state == StReady);
  assign out_valid      = (r_state == StHold);
  assign load_done      = r_load_done;
  assign perm_err       = r_perm_err;
  assign encrypt_buf    = r_enc_buf;
  assign crypt_mode_buf = r_cm_buf;
  assign out_symbol     = r_out_sym;
  assign rotorB_forward = r_fwd;

endmodule
